dmem_lsu: RTL and testbench

Parametrised, multi-cycle data memory with a load/store front end for the next-generation RISC-V core. Replaces the single-cycle, word-only data memory: adds byte/halfword/word accesses with sign/zero extension, configurable access latency behind a request/response handshake, and range checking. Sits between the processor's memory stage and the data storage array; one access outstanding at a time.

---
 rtl/dmem_lsu.sv | 102 ++++++++++
 tb/tb_dmem_lsu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: multi-cycle byte/half/word data memory with request/response handshake.
// Optional feature macro: DMEM_LSU_ALIGN_CHECK_EN (misaligned half/word accesses become errors).
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req, i_we, i_size, i_unsigned_ld, i_addr, i_wdata   request (sampled when o_ready=1)
//   o_ready                        request can be accepted this cycle
//   o_resp_valid, o_resp_err, o_rdata   one-cycle response, error flag, extended load data
module dmem_lsu #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_ld,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_resp_valid,
  output logic        o_resp_err,
  output logic [31:0] o_rdata
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_word;
  logic        r_we, r_err, r_uns;
  logic [1:0]  r_size, r_lane;
  logic        w_accept, w_err, w_misalign;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  assign o_ready      = (r_state == IDLE) || (r_cnt == 4'd0);
  assign o_resp_valid = (r_state == BUSY) && (r_cnt == 4'd0);
  // the array has no reset, so nothing may be accepted while reset is asserted
  assign w_accept     = i_req & o_ready & i_rst_n;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
  assign w_misalign = (i_size == 2'b01 && i_addr[0]) || (i_size == 2'b10 && i_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = (i_size == 2'b11) || (i_addr[31:AW+2] != '0) || w_misalign;
  assign w_idx = i_addr[AW+1:2];
  assign w_be  = i_size == 2'b00 ? 4'b0001 << i_addr[1:0] :
                 i_size == 2'b01 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // replicate narrow store data so every lane carries it; the byte enables pick the lane
  assign w_wd  = i_size == 2'b00 ? {4{i_wdata[7:0]}} :
                 i_size == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      w_state_nxt = BUSY;
      w_cnt_nxt   = 4'(LATENCY - 1);
    end else if (o_resp_valid) w_state_nxt = IDLE;
    else if (r_state == BUSY) w_cnt_nxt = r_cnt - 4'd1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we   <= 1'b0;
      r_err  <= 1'b0;
      r_uns  <= 1'b0;
      r_size <= '0;
      r_lane <= '0;
    end else if (w_accept) begin
      r_we   <= i_we;
      r_err  <= w_err;
      r_uns  <= i_unsigned_ld;
      r_size <= i_size;
      r_lane <= i_addr[1:0];
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      if (!w_err && i_we)
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
      r_word <= r_mem[w_idx];
    end
  end
  assign w_byte = r_word[8*r_lane +: 8];
  assign w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
  assign w_ext  = r_size == 2'b00 ? {{24{~r_uns & w_byte[7]}}, w_byte} :
                  r_size == 2'b01 ? {{16{~r_uns & w_half[15]}}, w_half} : r_word;
  assign o_resp_err = o_resp_valid & r_err;
  assign o_rdata    = (o_resp_valid & ~r_err & ~r_we) ? w_ext : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized + directed check of dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, rvalid, rerr;
  logic [31:0] rdata;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned_ld(uns), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready), .o_resp_valid(rvalid), .o_resp_err(rerr), .o_rdata(rdata));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte-addressed storage, one pending response with a due cycle
  logic [7:0]  mem_b [4*DEPTH];
  int          cyc = 0, due = 0;
  bit          pend = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_rdata = '0;

  function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
    return s == 2'd3 || a >= 32'(4*DEPTH) ||
           (ALIGN && ((s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)));
  endfunction

  function automatic logic [31:0] load_val(input logic [1:0] s, input bit u, input logic [31:0] a);
    int ba;
    logic [31:0] v;
    if (s == 2'd0) begin
      ba = int'(a);
      v = {24'd0, mem_b[ba]};
      if (!u && v[7]) v = v - 32'h100;
    end else if (s == 2'd1) begin
      ba = int'(a) & ~1;
      v = {16'd0, mem_b[ba+1], mem_b[ba]};
      if (!u && v[15]) v = v - 32'h10000;
    end else begin
      ba = int'(a) & ~3;
      v = {mem_b[ba+3], mem_b[ba+2], mem_b[ba+1], mem_b[ba]};
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend = 1'b0;
    else begin
      if (req && (!pend || cyc == due)) begin
        m_err = is_err(size, addr);
        m_rdata = '0;
        if (!m_err && we) begin
          int ba;
          ba = int'(addr);
          if (size == 2'd0) mem_b[ba] = wdata[7:0];
          else if (size == 2'd1) begin
            ba = ba & ~1;
            mem_b[ba] = wdata[7:0]; mem_b[ba+1] = wdata[15:8];
          end else begin
            ba = ba & ~3;
            for (int k = 0; k < 4; k++) mem_b[ba+k] = wdata[8*k +: 8];
          end
        end else if (!m_err) m_rdata = load_val(size, uns, addr);
        pend = 1'b1;
        due  = cyc + LAT;
      end else if (pend && cyc == due) pend = 1'b0;
      cyc++;
    end
  end

  always @(negedge clk) begin
    bit v;
    v = rst_n && pend && cyc == due;
    chk("ready", ready, !pend || cyc == due);
    chk("resp_valid", rvalid, v);
    if (v) begin
      chk("resp_err", rerr, m_err);
      chk("rdata", rdata, m_rdata);
    end else if (!rst_n) begin
      chk("rst_resp_err", rerr, 0);
      chk("rst_rdata", rdata, 0);
    end
  end

  task automatic issue(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (ready) break;
      if (n > 20) begin chk("ready_timeout", 0, 1); break; end
    end
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic access(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    issue(w, s, u, a, d);
    lat = 0; rd = 'x; er = 1'bx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (rvalid) begin rd = rdata; er = rerr; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic er;
    int lat, pulses;
    logic [1:0] s;
    req = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1; req = 1'b0;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'd2, 1'b0, 32'(4*i), $urandom);
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("st_lat", lat, 3); chk("st_err", er, 0); chk("st_rdata", rd, 0);
    access(1'b0, 2'd2, 1'b0, 32'h10, 0, rd, er, lat);
    chk("ld_lat", lat, 3); chk("ld_word", rd, 32'hDEADBEEF);
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
    access(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd, er, lat);
    access(1'b0, 2'd0, 1'b0, 32'h13, 0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b1, 32'h13, 0, rd, er, lat);
    chk("lb_unsigned", rd, 32'h00000080);
    access(1'b0, 2'd2, 1'b0, 32'h10, 0, rd, er, lat);
    chk("lw_after_sb", rd, 32'h80000000);
    access(1'b0, 2'd1, 1'b0, 32'h12, 0, rd, er, lat);
    chk("lh_signed", rd, 32'hFFFF8000);
    access(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344, rd, er, lat);
    access(1'b0, 2'd2, 1'b0, 32'h100, 0, rd, er, lat);
    chk("oor_ld_err", er, 1); chk("oor_ld_rdata", rd, 0);
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'hFFFFFFFF, rd, er, lat);
    chk("oor_st_err", er, 1);
    access(1'b0, 2'd2, 1'b0, 32'h0, 0, rd, er, lat);
    chk("oor_st_nowrite", rd, 32'h11223344);
    access(1'b0, 2'd3, 1'b0, 32'h0, 0, rd, er, lat);
    chk("size11_err", er, 1);
    access(1'b0, 2'd2, 1'b0, 32'h12, 0, rd, er, lat);
    chk("misalign_err", er, ALIGN ? 1 : 0);
    chk("misalign_rdata", rd, ALIGN ? 32'h0 : 32'h80000000);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    #1 rst_n = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (rvalid) pulses++; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (rvalid) pulses++; end
    chk("rst_no_pulse", pulses, 0);
    @(posedge clk);
    #1;
    access(1'b0, 2'd2, 1'b0, 32'h20, 0, rd, er, lat);
    chk("post_rst_lat", lat, 3); chk("post_rst_store_kept", rd, 32'hCAFEF00D);
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 15));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    repeat (LAT + 2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
